// File: rtl/mem_stage_if.sv
// Bundles the EXE->MEM, MEM->WB, data-memory response and ID bypass signals of
// the memory stage. The slave modport is the stage and the master modport is its environment.
interface mem_stage_if;
    logic        es_to_ms_valid;
    logic        ms_allow_in;
    logic        ms_to_ws_valid;
    logic        ws_allow_in;
    logic        flush;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic [31:0] es_sram_addr;
    logic [3:0]  es_mem_op;
    logic [3:0]  es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic        es_csr_we;
    logic [13:0] es_csr_num;
    logic [31:0] es_csr_wdata;
    logic [4:0]  es_csr_wmask;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [31:0] ms_pc;
    logic [3:0]  ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_csr_we;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_csr_wdata;
    logic [4:0]  ms_csr_wmask;
    logic        ms_ex;
    logic [5:0]  ms_ecode;
    logic [31:0] ms_badv;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_waddr;
    logic [31:0] ms_fwd_wdata;
    logic        ms_load_stall;

    modport slave (
        input  es_to_ms_valid, ws_allow_in, flush, es_pc, es_alu_result, es_sram_addr,
               es_mem_op, es_rf_we, es_rf_waddr, es_csr_we, es_csr_num, es_csr_wdata,
               es_csr_wmask, data_sram_data_ok, data_sram_rdata,
        output ms_allow_in, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
               ms_csr_we, ms_csr_num, ms_csr_wdata, ms_csr_wmask, ms_ex, ms_ecode,
               ms_badv, ms_fwd_valid, ms_fwd_waddr, ms_fwd_wdata, ms_load_stall
    );

    modport master (
        output es_to_ms_valid, ws_allow_in, flush, es_pc, es_alu_result, es_sram_addr,
               es_mem_op, es_rf_we, es_rf_waddr, es_csr_we, es_csr_num, es_csr_wdata,
               es_csr_wmask, data_sram_data_ok, data_sram_rdata,
        input  ms_allow_in, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
               ms_csr_we, ms_csr_num, ms_csr_wdata, ms_csr_wmask, ms_ex, ms_ecode,
               ms_badv, ms_fwd_valid, ms_fwd_waddr, ms_fwd_wdata, ms_load_stall
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for load responses, extracts load data and handles flush.
// Optional alignment exceptions are enabled by defining MEM_ALE_CHECK_EN.
module mem_stage (
    input  logic   clk,
    input  logic   reset,
    mem_stage_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic        ms_valid_q, ms_valid_d;
    logic        cancel_q, cancel_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] alu_q, alu_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [3:0]  mem_op_q, mem_op_d;
    logic [3:0]  rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic        csr_we_q, csr_we_d;
    logic [13:0] csr_num_q, csr_num_d;
    logic [31:0] csr_wdata_q, csr_wdata_d;
    logic [4:0]  csr_wmask_q, csr_wmask_d;
    logic        ex_q, ex_d;
    logic [31:0] badv_q, badv_d;

    logic        es_is_load, es_is_mem, es_ale;
    logic        load_wait, data_ok_live, ready_go, allow_in, accept;
    logic [31:0] load_word, load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign es_is_load = bus.es_mem_op[3];
    assign es_is_mem  = bus.es_mem_op[3] | bus.es_mem_op[2];

`ifdef MEM_ALE_CHECK_EN
    assign es_ale = es_is_mem &&
                    ((bus.es_mem_op[1:0] == 2'b01 && bus.es_sram_addr[0]) ||
                     (bus.es_mem_op[1:0] == 2'b10 && bus.es_sram_addr[1:0] != 2'b00));
`else
    assign es_ale = 1'b0;
`endif

    // A response seen while cancel is set belongs to a flushed load and is dropped.
    assign load_wait    = ms_valid_q && mem_op_q[3] && !ex_q;
    assign data_ok_live = bus.data_sram_data_ok && !cancel_q;
    assign ready_go     = !load_wait || (state_q == S_WAIT && data_ok_live) || (state_q == S_HOLD);
    assign allow_in     = !ms_valid_q || (ready_go && bus.ws_allow_in);
    assign accept       = bus.es_to_ms_valid && allow_in && !bus.flush;

    assign load_word = (state_q == S_HOLD) ? buf_q : bus.data_sram_rdata;
    assign load_byte = load_word[{addr_lo_q, 3'b000} +: 8];
    assign load_half = addr_lo_q[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        case (mem_op_q)
            4'b1000: load_data = {{24{load_byte[7]}}, load_byte};
            4'b1100: load_data = {24'h0, load_byte};
            4'b1001: load_data = {{16{load_half[15]}}, load_half};
            4'b1101: load_data = {16'h0, load_half};
            default: load_data = load_word;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts at its _q so no path leaves a signal unassigned (no latches).
        state_d     = state_q;
        ms_valid_d  = ms_valid_q;
        cancel_d    = cancel_q;
        buf_d       = buf_q;
        pc_d        = pc_q;
        alu_d       = alu_q;
        addr_lo_d   = addr_lo_q;
        mem_op_d    = mem_op_q;
        rf_we_d     = rf_we_q;
        rf_waddr_d  = rf_waddr_q;
        csr_we_d    = csr_we_q;
        csr_num_d   = csr_num_q;
        csr_wdata_d = csr_wdata_q;
        csr_wmask_d = csr_wmask_q;
        ex_d        = ex_q;
        badv_d      = badv_q;

        if (bus.flush)
            ms_valid_d = 1'b0;
        else if (allow_in)
            ms_valid_d = bus.es_to_ms_valid;

        if (cancel_q && bus.data_sram_data_ok)
            cancel_d = 1'b0;
        if (bus.flush && state_q == S_WAIT && !bus.data_sram_data_ok)
            cancel_d = 1'b1;

        if (state_q == S_WAIT && data_ok_live && !bus.ws_allow_in && !bus.flush)
            buf_d = bus.data_sram_rdata;

        if (accept) begin
            pc_d        = bus.es_pc;
            alu_d       = bus.es_alu_result;
            addr_lo_d   = bus.es_sram_addr[1:0];
            mem_op_d    = bus.es_mem_op;
            rf_we_d     = es_ale ? 4'h0 : bus.es_rf_we;
            rf_waddr_d  = bus.es_rf_waddr;
            csr_we_d    = bus.es_csr_we;
            csr_num_d   = bus.es_csr_num;
            csr_wdata_d = bus.es_csr_wdata;
            csr_wmask_d = bus.es_csr_wmask;
            ex_d        = es_ale;
            badv_d      = es_ale ? bus.es_sram_addr : 32'h0;
        end

        // A load accepted while cancel is pending waits in IDLE until the stale response drains.
        if (bus.flush) begin
            state_d = S_IDLE;
        end else if (accept) begin
            state_d = (es_is_load && !es_ale && !cancel_d) ? S_WAIT : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (load_wait && !cancel_d) state_d = S_WAIT;
                S_WAIT: if (data_ok_live) state_d = bus.ws_allow_in ? S_IDLE : S_HOLD;
                S_HOLD: if (bus.ws_allow_in) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: synchronous reset; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ms_valid_q  <= 1'b0;
            cancel_q    <= 1'b0;
            buf_q       <= 32'h0;
            pc_q        <= 32'h1c00_0000;
            alu_q       <= 32'h0;
            addr_lo_q   <= 2'b00;
            mem_op_q    <= 4'h0;
            rf_we_q     <= 4'h0;
            rf_waddr_q  <= 5'h0;
            csr_we_q    <= 1'b0;
            csr_num_q   <= 14'h0;
            csr_wdata_q <= 32'h0;
            csr_wmask_q <= 5'h0;
            ex_q        <= 1'b0;
            badv_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            ms_valid_q  <= ms_valid_d;
            cancel_q    <= cancel_d;
            buf_q       <= buf_d;
            pc_q        <= pc_d;
            alu_q       <= alu_d;
            addr_lo_q   <= addr_lo_d;
            mem_op_q    <= mem_op_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            csr_we_q    <= csr_we_d;
            csr_num_q   <= csr_num_d;
            csr_wdata_q <= csr_wdata_d;
            csr_wmask_q <= csr_wmask_d;
            ex_q        <= ex_d;
            badv_q      <= badv_d;
        end
    end

    assign bus.ms_allow_in    = allow_in;
    assign bus.ms_to_ws_valid = ms_valid_q && ready_go && !bus.flush;
    assign bus.ms_pc          = pc_q;
    assign bus.ms_rf_we       = ms_valid_q ? rf_we_q : 4'h0;
    assign bus.ms_rf_waddr    = rf_waddr_q;
    assign bus.ms_rf_wdata    = (mem_op_q[3] && !ex_q) ? load_data : alu_q;
    assign bus.ms_csr_we      = ms_valid_q && csr_we_q;
    assign bus.ms_csr_num     = csr_num_q;
    assign bus.ms_csr_wdata   = csr_wdata_q;
    assign bus.ms_csr_wmask   = csr_wmask_q;
    assign bus.ms_ex          = ex_q;
    assign bus.ms_ecode       = ex_q ? 6'h09 : 6'h00;
    assign bus.ms_badv        = badv_q;
    assign bus.ms_fwd_valid   = ms_valid_q && (|rf_we_q);
    assign bus.ms_fwd_waddr   = rf_waddr_q;
    assign bus.ms_fwd_wdata   = bus.ms_rf_wdata;
    assign bus.ms_load_stall  = ms_valid_q && mem_op_q[3] && !ready_go;
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  clock; all state updates on the rising edge.
REQ-002 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-003 es_to_ms_valid / ms_allow_in  in / out  1 / 1  upstream valid / ready handshake.
REQ-004 ms_to_ws_valid / ws_allow_in  out / in  1 / 1  downstream valid / ready handshake.
REQ-005 flush  in  1  exception or ertn flush from WB.
REQ-006 es_pc, es_alu_result, es_sram_addr  in  32 each  EXE payload.
REQ-007 es_mem_op  in  4  memory op: 0000 none, 1000 ld.b, 1001 ld.h, 1010 ld.w, 1100 ld.bu, 1101 ld.hu, 0100 st.b, 0101 st.h, 0110 st.w.
REQ-008 es_rf_we, es_rf_waddr  in  4 / 5  register write enable and address.
REQ-009 es_csr_we, es_csr_num, es_csr_wdata, es_csr_wmask  in  1 / 14 / 32 / 5  CSR payload, passed through.
REQ-010 data_sram_data_ok, data_sram_rdata  in  1 / 32  load response from data memory.
REQ-011 ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata, CSR outputs  out  matching widths  registered payload to WB.
REQ-012 ms_ex, ms_ecode, ms_badv  out  1 / 6 / 32  exception flag, exception code, bad virtual address.
REQ-013 ms_fwd_valid, ms_fwd_waddr, ms_fwd_wdata, ms_load_stall  out  1 / 5 / 32 / 1  bypass to ID.

Function
REQ-014 Stage SHALL accept new input when es_to_ms_valid && ms_allow_in, where ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in).
REQ-015 On accept, the payload SHALL be registered and appear on outputs the next cycle (latency 1).
REQ-016 ms_ready_go SHALL be 1 for non-loads and for excepted instructions.
REQ-017 For loads, ms_ready_go SHALL be 1 once data_sram_data_ok is seen or the response buffer is full.
REQ-018 FSM states: IDLE, WAIT, HOLD.
- IDLE -> WAIT on accepting a load with no exception.
- WAIT -> IDLE when data_ok && ws_allow_in.
- WAIT -> HOLD when data_ok && !ws_allow_in; the response is captured into a 32-bit buffer.
- HOLD -> IDLE when ws_allow_in.
REQ-019 Load result SHALL be extracted by es_sram_addr[1:0].
- ld.b / ld.bu: sign- or zero-extended byte.
- ld.h / ld.hu: sign- or zero-extended halfword at addr[1].
- ld.w: full word.
REQ-020 ms_rf_wdata SHALL be the extracted load data for loads and the registered alu_result otherwise.
REQ-021 ms_to_ws_valid SHALL equal ms_valid && ms_ready_go && !flush.
REQ-022 flush SHALL clear ms_valid and force the FSM to IDLE on the next edge.
REQ-023 A data_ok arriving after a flush of a pending load SHALL be discarded: a 1-bit cancel counter is set on flush-in-WAIT and cleared on the discarded data_ok, and no new load leaves IDLE for WAIT while it is set.
REQ-024 If flush and an accept occur in the same cycle, the new instruction SHALL NOT be accepted.
REQ-025 Forwarding outputs:
- ms_fwd_valid = ms_valid && |ms_rf_we.
- ms_load_stall = ms_valid && load && !ms_ready_go.
- ms_fwd_wdata = ms_rf_wdata.
REQ-026 When ms_valid = 0, ms_rf_we and ms_csr_we SHALL output 0.

Reset
REQ-027 On reset the following SHALL be cleared in the same edge:
- ms_valid = 0, FSM = IDLE, buffer = 0, cancel = 0.
- ms_pc = 32'h1c000000.
- All other registered payload = 0.
- ms_ex = 0, ms_ecode = 0, ms_badv = 0.
REQ-028 Reset mid-WAIT SHALL abandon the load with no output effect.

Configuration
REQ-029 Macro MEM_ALE_CHECK_EN enables alignment checking.
- Defined: the following SHALL set ms_ex = 1, ms_ecode = 6'h09, ms_badv = es_sram_addr, force rf_we = 0, and suppress the WAIT transition:
  - halfword access with addr[0] = 1.
  - word access with addr[1:0] != 0.
- Undefined: ms_ex, ms_ecode, ms_badv SHALL tie to 0 and misaligned accesses proceed normally.

Verification
REQ-030 ld.w, addr 0x100, data_ok one cycle after accept with rdata 0x8000_00FF, ws_allow_in = 1 -> ms_rf_wdata = 0x800000FF and ms_to_ws_valid high that cycle.
REQ-031 ld.b, addr 0x103, rdata 0x80112233 -> ms_rf_wdata = 0xFFFFFF80; same access with ld.bu -> 0x00000080.
REQ-032 data_ok while ws_allow_in = 0 for 3 cycles -> FSM in HOLD, data retained, one transfer when ws_allow_in rises, no duplicate.
REQ-033 Flush in WAIT, data_ok two cycles later, new load already queued -> stale data discarded, new load gets its own response.
REQ-034 With MEM_ALE_CHECK_EN, ld.w at 0x102 -> ms_ex = 1, ms_ecode = 0x09, ms_badv = 0x102, rf_we = 0, no wait; without the macro -> normal load.
REQ-035 Reset asserted in WAIT -> next cycle ms_valid = 0, ms_pc = 0x1c000000, ms_allow_in = 1.
